// File: rtl/piezo_alert_sched.sv
// Buzzer owner arbitration and melody sequencing for the piezo tone engine.
// Issues one note at a time and owns the repeat timer for periodic alerts.
module piezo_alert_sched #(
  parameter int FAST_SIM   = 1,
  parameter int REPEAT_CYC = 150_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       too_fast_req,
  input  logic       batt_low_req,
  input  logic       en_steer_req,
  output logic       note_vld,
  input  logic       note_rdy,
  output logic [1:0] note_code,
  output logic [1:0] note_len,
  input  logic       note_done,
  output logic       note_abort,
  output logic [1:0] cur_src
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    PLAY
  } state_e;

  localparam logic [27:0] RPT  = 28'(REPEAT_CYC);
  localparam logic [27:0] STEP = (FAST_SIM != 0) ? 28'd64 : 28'd1;

  localparam logic [1:0] SRC_NONE  = 2'd0;
  localparam logic [1:0] SRC_FAST  = 2'd1;
  localparam logic [1:0] SRC_BATT  = 2'd2;
  localparam logic [1:0] SRC_STEER = 2'd3;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  src_q, src_d;
  logic [1:0]  code_q, code_d;
  logic [1:0]  len_q, len_d;
  logic        vld_q, vld_d;
  logic        abort_q, abort_d;
  logic [27:0] tmr_q, tmr_d;

  logic        rpt_exp;
  logic        own_req;
  logic        last_idx;
  logic        preempt;
  logic [2:0]  nxt_idx;

  // {code, len} per melody index
  function automatic logic [3:0] melody(input logic [2:0] i);
    case (i)
      3'd0:    melody = {2'd0, 2'd1};
      3'd1:    melody = {2'd1, 2'd1};
      3'd2:    melody = {2'd2, 2'd1};
      3'd3:    melody = {2'd3, 2'd2};
      3'd4:    melody = {2'd2, 2'd0};
      default: melody = {2'd3, 2'd3};
    endcase
  endfunction

  assign rpt_exp = (tmr_q >= RPT);
  assign preempt = too_fast_req &&
                   ((src_q == SRC_BATT) || (src_q == SRC_STEER));

  always_comb begin
    own_req  = 1'b0;
    last_idx = 1'b0;
    nxt_idx  = idx_q + 3'd1;
    unique case (1'b1)
      (src_q == SRC_FAST): begin
        own_req  = too_fast_req;
        last_idx = (idx_q == 3'd2);
      end
      (src_q == SRC_BATT): begin
        own_req  = batt_low_req;
        last_idx = (idx_q == 3'd0);
        nxt_idx  = idx_q - 3'd1;
      end
      (src_q == SRC_STEER): begin
        own_req  = en_steer_req;
        last_idx = (idx_q == 3'd5);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    src_d   = src_q;
    code_d  = code_q;
    len_d   = len_q;
    vld_d   = 1'b0;
    abort_d = 1'b0;
    tmr_d   = rpt_exp ? tmr_q : tmr_q + STEP;
    unique case (state_q)
      IDLE: begin
        if (too_fast_req) begin
          state_d         = ISSUE;
          src_d           = SRC_FAST;
          idx_d           = 3'd0;
          vld_d           = 1'b1;
          {code_d, len_d} = melody(3'd0);
        end else if (rpt_exp && batt_low_req) begin
          state_d         = ISSUE;
          src_d           = SRC_BATT;
          idx_d           = 3'd5;
          vld_d           = 1'b1;
          {code_d, len_d} = melody(3'd5);
          tmr_d           = '0;
        end else if (rpt_exp && en_steer_req) begin
          state_d         = ISSUE;
          src_d           = SRC_STEER;
          idx_d           = 3'd0;
          vld_d           = 1'b1;
          {code_d, len_d} = melody(3'd0);
          tmr_d           = '0;
        end
      end
      ISSUE: begin
        if (preempt) begin
          src_d = SRC_FAST;
          idx_d = 3'd0;
        end else if (!own_req) begin
          state_d = IDLE;
          src_d   = SRC_NONE;
        end else if (vld_q && note_rdy) begin
          state_d = PLAY;
        end else begin
          // also re-raises vld after a preemption dropped it
          vld_d           = 1'b1;
          {code_d, len_d} = melody(idx_q);
        end
      end
      PLAY: begin
        if (preempt) begin
          state_d = ISSUE;
          abort_d = 1'b1;
          src_d   = SRC_FAST;
          idx_d   = 3'd0;
        end else if (!own_req) begin
          state_d = IDLE;
          abort_d = 1'b1;
          src_d   = SRC_NONE;
        end else if (note_done) begin
          if (last_idx && (src_q != SRC_FAST)) begin
            state_d = IDLE;
            src_d   = SRC_NONE;
          end else if (last_idx) begin
            state_d         = ISSUE;
            idx_d           = 3'd0;
            vld_d           = 1'b1;
            {code_d, len_d} = melody(3'd0);
          end else begin
            state_d         = ISSUE;
            idx_d           = nxt_idx;
            vld_d           = 1'b1;
            {code_d, len_d} = melody(nxt_idx);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      src_q   <= SRC_NONE;
      code_q  <= '0;
      len_q   <= '0;
      vld_q   <= 1'b0;
      abort_q <= 1'b0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      src_q   <= src_d;
      code_q  <= code_d;
      len_q   <= len_d;
      vld_q   <= vld_d;
      abort_q <= abort_d;
      tmr_q   <= tmr_d;
    end
  end

  assign note_vld   = vld_q;
  assign note_code  = code_q;
  assign note_len   = len_q;
  assign note_abort = abort_q;
  assign cur_src    = src_q;

endmodule

// File: tb/tb_piezo_alert_sched.sv
// Directed bench for piezo_alert_sched with a small tone-engine model.
// Engine accepts on vld&rdy and pulses done 10 clks later unless aborted.
module tb_piezo_alert_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       too_fast_req = 1'b0;
  logic       batt_low_req = 1'b0;
  logic       en_steer_req = 1'b0;
  logic       note_rdy = 1'b1;
  logic       eng_done = 1'b0;
  logic       man_done = 1'b0;
  logic       note_done;
  logic       note_vld;
  logic [1:0] note_code;
  logic [1:0] note_len;
  logic       note_abort;
  logic [1:0] cur_src;

  int n_vec = 0;
  int n_err = 0;

  bit          auto_done = 1'b1;
  int unsigned cnt = 0;
  logic [1:0]  acc_code[$];
  logic [1:0]  acc_len[$];
  logic [1:0]  acc_src[$];

  assign note_done = eng_done | man_done;

  piezo_alert_sched #(
    .FAST_SIM  (1),
    .REPEAT_CYC(6400)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .too_fast_req(too_fast_req),
    .batt_low_req(batt_low_req),
    .en_steer_req(en_steer_req),
    .note_vld    (note_vld),
    .note_rdy    (note_rdy),
    .note_code   (note_code),
    .note_len    (note_len),
    .note_done   (note_done),
    .note_abort  (note_abort),
    .cur_src     (cur_src)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    eng_done = 1'b0;
    if (!rst_n) begin
      cnt = 0;
    end else begin
      if (note_abort) cnt = 0;
      if (cnt != 0) begin
        cnt = cnt - 1;
        if (cnt == 0) eng_done = 1'b1;
      end
      if (note_vld && note_rdy) begin
        acc_code.push_back(note_code);
        acc_len.push_back(note_len);
        acc_src.push_back(cur_src);
        if (auto_done) cnt = 10;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    too_fast_req = 1'b0;
    batt_low_req = 1'b0;
    en_steer_req = 1'b0;
    note_rdy     = 1'b1;
    man_done     = 1'b0;
    auto_done    = 1'b1;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_acc(input int n, input int budget);
    for (int i = 0; i < budget && acc_code.size() < n; i++)
      @(negedge clk);
    chk("acc_cnt", acc_code.size(), n);
  endtask

  logic [1:0] fwd_c[6] = '{0, 1, 2, 3, 2, 3};
  logic [1:0] fwd_l[6] = '{1, 1, 1, 2, 0, 3};
  logic [1:0] rev_c[6] = '{3, 2, 3, 2, 1, 0};
  logic [1:0] rev_l[6] = '{3, 0, 2, 1, 1, 1};
  logic [1:0] tf_c[6]  = '{0, 1, 2, 0, 1, 2};

  initial begin
    int base;
    int k;
    int cntv;
    bit saw_idle;

    @(negedge clk);
    chk("rst_vld", note_vld, 0);
    chk("rst_abort", note_abort, 0);
    chk("rst_code", note_code, 0);
    chk("rst_len", note_len, 0);
    chk("rst_src", cur_src, 0);

    // 1: steering chime, first note after 100 timer clks
    do_reset();
    en_steer_req = 1'b1;
    base = acc_code.size();
    tick(100);
    chk("t1_vld_early", note_vld, 0);
    tick(1);
    chk("t1_vld", note_vld, 1);
    chk("t1_src", cur_src, 3);
    chk("t1_code0", note_code, 0);
    chk("t1_len0", note_len, 1);
    k = 0;
    saw_idle = 1'b0;
    while (k < 300 && !(acc_code.size() >= base + 6 && note_vld)) begin
      @(negedge clk);
      k++;
      if (acc_code.size() >= base + 6 && cur_src == 2'd0) saw_idle = 1'b1;
    end
    chk("t1_idle_between", saw_idle, 1);
    chk("t1_repeat_win", (k >= 95 && k <= 105), 1);
    chk("t1_rep_code", note_code, 0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_code%0d", i), acc_code[base+i], fwd_c[i]);
      chk($sformatf("t1_len%0d", i), acc_len[base+i], fwd_l[i]);
    end

    // 2: battery beats steering, reverse melody
    do_reset();
    batt_low_req = 1'b1;
    en_steer_req = 1'b1;
    base = acc_code.size();
    tick(101);
    chk("t2_vld", note_vld, 1);
    chk("t2_src", cur_src, 2);
    wait_acc(base + 6, 200);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t2_code%0d", i), acc_code[base+i], rev_c[i]);
      chk($sformatf("t2_len%0d", i), acc_len[base+i], rev_l[i]);
      chk($sformatf("t2_src%0d", i), acc_src[base+i], 2);
    end

    // 3: overspeed preempts steering during idx 3
    do_reset();
    en_steer_req = 1'b1;
    base = acc_code.size();
    wait_acc(base + 4, 250);
    chk("t3_idx3_code", acc_code[base+3], 3);
    too_fast_req = 1'b1;
    tick(1);
    chk("t3_abort", note_abort, 1);
    chk("t3_src", cur_src, 1);
    chk("t3_vld_drop", note_vld, 0);
    tick(1);
    chk("t3_abort_1clk", note_abort, 0);
    chk("t3_vld", note_vld, 1);
    chk("t3_code", note_code, 0);
    wait_acc(base + 10, 200);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_code%0d", i), acc_code[base+4+i], tf_c[i]);
      chk($sformatf("t3_src%0d", i), acc_src[base+4+i], 1);
    end
    too_fast_req = 1'b0;
    en_steer_req = 1'b0;
    tick(2);
    chk("t3_end_src", cur_src, 0);

    // 4: engine stalls 20 clks, command held stable
    do_reset();
    note_rdy = 1'b0;
    too_fast_req = 1'b1;
    base = acc_code.size();
    tick(1);
    chk("t4_vld", note_vld, 1);
    chk("t4_src", cur_src, 1);
    cntv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (note_vld === 1'b1 && note_code === 2'd0 && note_len === 2'd1)
        cntv++;
    end
    chk("t4_stable", cntv, 20);
    chk("t4_no_xfer", acc_code.size(), base);
    note_rdy = 1'b1;
    tick(1);
    note_rdy = 1'b0;
    tick(3);
    chk("t4_one_xfer", acc_code.size(), base + 1);
    chk("t4_vld_off", note_vld, 0);
    too_fast_req = 1'b0;
    tick(1);
    chk("t4_loss_abort", note_abort, 1);
    chk("t4_loss_src", cur_src, 0);

    // 5: request loss and done in the same clk
    do_reset();
    en_steer_req = 1'b1;
    auto_done = 1'b0;
    tick(101);
    chk("t5_vld", note_vld, 1);
    tick(3);
    chk("t5_play", note_vld, 0);
    man_done = 1'b1;
    en_steer_req = 1'b0;
    tick(1);
    man_done = 1'b0;
    chk("t5_abort", note_abort, 1);
    chk("t5_src", cur_src, 0);
    cntv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (note_vld !== 1'b0 || note_abort !== 1'b0) cntv++;
    end
    chk("t5_quiet", cntv, 0);

    // 6: async reset during PLAY, then full interval before reissue
    do_reset();
    en_steer_req = 1'b1;
    base = acc_code.size();
    wait_acc(base + 3, 250);
    chk("t6_pre_code", note_code, 2);
    chk("t6_pre_src", cur_src, 3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_src", cur_src, 0);
    chk("t6_rst_code", note_code, 0);
    chk("t6_rst_len", note_len, 0);
    chk("t6_rst_vld", note_vld, 0);
    chk("t6_rst_abort", note_abort, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cntv = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (note_vld !== 1'b0 || note_abort !== 1'b0) cntv++;
    end
    chk("t6_quiet", cntv, 0);
    tick(1);
    chk("t6_reissue", note_vld, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
